fetch_stage: RTL and testbench

Instruction-fetch stage of the mini-rv core. Holds the program counter, drives the word address into the instruction memory (asynchronous-read ROM), and captures the returned word into the IF/ID pipeline register with PC metadata for decode. Handles decode back-pressure (stall), execute-stage control-flow redirects, and halts on a misaligned or out-of-range fetch address until it is redirected.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID register; halts on an illegal fetch address until redirected.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;
    logic        pc_illegal;

    // Range check is a full 32-bit compare so wrapped/huge targets still fault.
    assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_q       <= 32'h0;
            id_pc_plus4_q <= 32'h0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
            count_q       <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        count_d       = count_q;

        if (redirect) begin
            // The word fetched this cycle is wrong-path; drop it even when stalled.
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            state_d    = RUN;
            fault_d    = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (pc_illegal) begin
                            state_d    = HALT;
                            fault_d    = 1'b1;
                            fault_pc_d = pc_q;
                            id_valid_d = 1'b0;
                        end else begin
                            id_instr_d    = imem_data;
                            id_pc_d       = pc_q;
                            id_pc_plus4_d = pc_q + 32'd4;
                            id_valid_d    = 1'b1;
                            pc_d          = pc_q + 32'd4;
                            count_d       = count_q + 32'd1;
                        end
                    end
                end
                HALT: begin
                    id_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random stall/redirect/reset
// traffic, every cycle compared against a behavioural model of the stage.
module tb_fetch_stage;

    localparam int          MEM_WORDS = 64;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data;
    logic        id_valid, fetch_fault;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fault_pc, fetch_count;

    logic [31:0] rom [0:MEM_WORDS-1];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_idpc, m_fpc, m_count;
    logic        m_valid, m_halted, m_fault;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault),
        .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    assign imem_data = (imem_addr < 32'(4 * MEM_WORDS) && imem_addr[1:0] == 2'b00)
                       ? rom[imem_addr[7:2]] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model by the stage's rules, compare all outputs.
    task automatic cycle(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
        reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_idpc = 0;
            m_fault = 0; m_fpc = 0; m_count = 0; m_halted = 0;
        end else if (rdr) begin
            m_pc = rpc; m_valid = 0; m_halted = 0; m_fault = 0;
        end else if (m_halted || stl) begin
            // nothing moves
        end else if (m_pc % 4 != 0 || m_pc >= 4 * MEM_WORDS) begin
            m_halted = 1; m_fault = 1; m_fpc = m_pc; m_valid = 0;
        end else begin
            m_instr = rom[m_pc / 4]; m_idpc = m_pc; m_valid = 1;
            m_pc = m_pc + 4; m_count = m_count + 1;
        end
        #1;
        $display("cyc rst=%0b stl=%0b rdr=%0b rpc=%08h | addr=%08h v=%0b instr=%08h pc=%08h flt=%0b fpc=%08h cnt=%0d",
                 rst, stl, rdr, rpc, imem_addr, id_valid, id_instr, id_pc, fetch_fault, fault_pc, fetch_count);
        check("imem_addr", imem_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("id_instr", id_instr, m_instr);
        check("id_pc", id_pc, m_idpc);
        check("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4 - ((m_idpc == 0 && m_count == 0) ? 32'd4 : 32'd0));
        check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        check("fault_pc", fault_pc, m_fpc);
        check("fetch_count", fetch_count, m_count);
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;
        bit          seen;

        for (int i = 0; i < MEM_WORDS; i++) rom[i] = $urandom;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

        // Reset and sequential fetch
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        check("seq_pc8", id_pc, 32'h8);
        check("seq_instr33", id_instr, 32'h33);

        // Stall holds IF/ID and the PC
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            check("stall_idpc", id_pc, 32'h8);
            check("stall_addr", imem_addr, 32'hC);
        end
        cycle(0, 0, 0, 0);
        check("post_stall_pc", id_pc, 32'hC);
        check("post_stall_instr", id_instr, 32'h44);
        check("post_stall_p4", id_pc_plus4, 32'h10);
        check("post_stall_cnt", fetch_count, 32'd4);

        // Redirect with stall: one bubble, then target
        cycle(0, 1, 1, 32'h20);
        check("rdr_bubble", 32'(id_valid), 32'h0);
        cycle(0, 0, 0, 0);
        check("rdr_target", id_pc, 32'h20);
        check("rdr_cnt", fetch_count, 32'd5);

        // Out-of-range fault at 0x100
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle(0, 0, 0, 0);
            seen = fetch_fault;
        end
        check("oor_seen", 32'(seen), 32'h1);
        check("oor_fpc", fault_pc, 32'h100);
        for (int i = 0; i < 5; i++) begin
            cycle(0, $urandom_range(0, 1), 0, 0);
            check("oor_hold", imem_addr, 32'h100);
        end

        // Misaligned redirect, then recovery
        cycle(0, 0, 1, 32'h6);
        cycle(0, 0, 0, 0);
        check("mis_fault", 32'(fetch_fault), 32'h1);
        check("mis_fpc", fault_pc, 32'h6);
        cycle(0, 0, 1, 32'h8);
        check("mis_clear", 32'(fetch_fault), 32'h0);
        cycle(0, 0, 0, 0);
        check("mis_recover", id_pc, 32'h8);

        // Reset during a fault and together with a redirect
        cycle(0, 0, 1, 32'hFFFF_FFF0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_fault", 32'(fetch_fault), 32'h0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 32'h40);
        check("rst_rdr_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: tgt = {$urandom_range(0, MEM_WORDS - 1), 2'b00};
                1: tgt = {$urandom_range(0, MEM_WORDS - 1), 2'b00} | $urandom_range(1, 3);
                2: tgt = 32'hFC;
                3: tgt = 32'h100;
                4: tgt = $urandom;
                default: tgt = 32'hE0;
            endcase
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
